stream_demux: RTL
=================

STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter DATA_WIDTH, default 8: payload width in bits.
REQ-002 Parameter N, default 4: output channel count, N >= 2, not required to be a power of two.
REQ-003 Localparam SEL_WIDTH = $clog2(N).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  upstream word present.
REQ-007 in_ready  output  1  upstream word accepted this cycle when in_valid & in_ready.
REQ-008 in_data  input  DATA_WIDTH  payload.
REQ-009 in_sel  input  SEL_WIDTH  destination channel, unicast mode.
REQ-010 in_bcast  input  1  1 = deliver the word to all N channels, in_sel ignored.
REQ-011 out_valid  output  N  bit j = channel j holds a word.
REQ-012 out_ready  input  N  bit j = channel j consumer takes the word.
REQ-013 out_data  output  N*DATA_WIDTH  channel j occupies bits [N*DATA_WIDTH-1-j*DATA_WIDTH -: DATA_WIDTH]; channel 0 is at the MSB end.
REQ-014 drop_cnt  output  16  saturating count of words discarded for an out-of-range in_sel.

Function
REQ-015 Each channel SHALL hold a one-entry register (slot): either EMPTY or FULL.
REQ-016 Slot j is free this cycle when it is EMPTY, or FULL with out_ready[j]=1 (drain and refill in the same cycle).
REQ-017 Target set: in_bcast=1 gives all channels; in_bcast=0 with in_sel<N gives channel in_sel only; in_sel>=N gives the empty set.
REQ-018 in_ready SHALL be 1 when every slot in the target set is free; in_ready is combinational on out_ready, slot state, in_sel and in_bcast.
REQ-019 For an empty target set, in_ready SHALL be 1; the word is discarded and drop_cnt increments by 1, saturating at 16'hFFFF.
REQ-020 On accept, every targeted slot SHALL load in_data and be FULL on the next cycle (latency 1 cycle); untargeted slots are unaffected.
REQ-021 A FULL slot with out_ready[j]=1 and no reload SHALL become EMPTY next cycle.
REQ-022 A FULL slot SHALL hold out_data and out_valid stable until out_ready[j]=1.
REQ-023 Broadcast is all-or-nothing: no partial delivery; it stalls until all N slots are free in the same cycle.
REQ-024 Sustained throughput SHALL be one word per cycle per target set while the targeted out_ready bits are held at 1.
REQ-025 out_data bits of an EMPTY slot SHALL retain the last loaded value; consumers use out_valid only.
REQ-026 in_ready SHALL be 0 while rst=1.

Reset
REQ-027 While rst=1 at a rising edge, all slots SHALL go EMPTY (out_valid=0), out_data SHALL be 0 and drop_cnt SHALL be 0.
REQ-028 Reset asserted mid-transfer SHALL discard all held words without output; the first accept is possible in the first cycle after rst deasserts.

Structure
REQ-029 The shared package SHALL hold the channel-bit-slice helper (start index for channel j) and the drop counter width constant (16); all packing across the block SHALL use that helper.
REQ-030 One sub-module demux_slot SHALL implement one channel: load, valid and hold, with a free output; the top instantiates N copies, plus the target decode, in_ready AND-reduction and drop counter.

Verification
REQ-031 N=4, DW=8: unicast 0xA5 with sel=2 and out_ready=4'b0000 -> next cycle out_valid=4'b0100 and channel 2 data=0xA5; in_ready=0 for a further sel=2 word.
REQ-032 Broadcast 0x3C with channel 1 FULL and out_ready[1]=0 -> in_ready=0 and no slot changes; raise out_ready[1] -> accept, next cycle out_valid=4'b1111, all data=0x3C.
REQ-033 N=3: in_sel=3, in_valid=1 for 5 cycles -> in_ready=1, out_valid unchanged, drop_cnt=5; force 70000 drops -> drop_cnt=16'hFFFF.
REQ-034 Back-to-back words 0x01..0x08 to sel=0 with out_ready[0]=1 -> one word per cycle on channel 0 in order, no bubbles.
REQ-035 rst pulsed for one cycle while all slots FULL -> next cycle out_valid=0, out_data=0, drop_cnt=0; a word offered in the first post-reset cycle is accepted.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the stream demultiplexer.
package stream_demux_pkg;

  // Width of the saturating drop counter.
  localparam int unsigned DROP_CNT_W = 16;

  // Occupancy of a single channel slot.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Start (most significant) bit of channel j in a packed bus of n channels.
  // Channel 0 sits at the MSB end.
  function automatic int unsigned chan_msb(input int unsigned n,
                                           input int unsigned dw,
                                           input int unsigned j);
    return (n * dw) - 1 - (j * dw);
  endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// One output channel: a single-entry register with valid/ready handshake.
module demux_slot
  import stream_demux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  out_ready,
  output logic                  free_c,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  slot_state_e state;
  slot_state_e state_nxt;

  // Slot occupancy register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SLOT_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Fill on load, drain when the consumer takes the word; a load wins over a drain.
  always_comb begin
    state_nxt = state;
    if (load) begin
      state_nxt = SLOT_FULL;
    end else if ((state == SLOT_FULL) && out_ready) begin
      state_nxt = SLOT_EMPTY;
    end
  end

  // Payload register; keeps the last loaded value after draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
    end else if (load) begin
      out_data <= load_data;
    end
  end

  assign out_valid = (state == SLOT_FULL);
  assign free_c    = (state == SLOT_EMPTY) || out_ready;

endmodule

// File: rtl/stream_demux.sv
// Routes an input stream to one of N channels, or to all of them on broadcast.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned N          = 4,
  localparam int unsigned SEL_WIDTH  = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [SEL_WIDTH-1:0]    in_sel,
  input  logic                    in_bcast,
  output logic [N-1:0]            out_valid,
  input  logic [N-1:0]            out_ready,
  output logic [N*DATA_WIDTH-1:0] out_data,
  output logic [DROP_CNT_W-1:0]   drop_cnt
);

  logic [N-1:0] target;
  logic [N-1:0] free_c;
  logic [N-1:0] load;
  logic         accept;
  logic         drop;

  // Target decode: all channels on broadcast, one on in-range select, none otherwise.
  always_comb begin
    target = '0;
    if (in_bcast) begin
      target = '1;
    end else begin
      for (int j = 0; j < int'(N); j++) begin
        if (in_sel == SEL_WIDTH'(j)) begin
          target[j] = 1'b1;
        end
      end
    end
  end

  // Accept only when every targeted slot can take the word this cycle.
  assign in_ready = ~rst & (&(free_c | ~target));
  assign accept   = in_valid & in_ready;
  assign load     = target & {N{accept}};
  assign drop     = accept & ~(|target);

  for (genvar j = 0; j < int'(N); j++) begin : g_slot
    localparam int unsigned MSB = chan_msb(N, DATA_WIDTH, j);
    demux_slot #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (load[j]),
      .load_data(in_data),
      .out_ready(out_ready[j]),
      .free_c   (free_c[j]),
      .out_valid(out_valid[j]),
      .out_data (out_data[MSB -: DATA_WIDTH])
    );
  end

  // Saturating count of words discarded for an out-of-range select.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != {DROP_CNT_W{1'b1}})) begin
      drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
  end

endmodule
